// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited sequential
// requests to imem, queues returned words with their PCs, and flushes on redirect.
module fetch_prefetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             mem_req_valid,
    output logic [31:0]      mem_req_addr,
    input  logic             mem_req_ready,
    input  logic             mem_resp_valid,
    input  logic [31:0]      mem_resp_data,
    output logic             dec_valid,
    output logic [31:0]      dec_pc,
    output logic [31:0]      dec_inst,
    input  logic             dec_ready,
    output logic [CNT_W-1:0] occupancy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if ((1 << CNT_W) <= DEPTH) begin : g_bad_cnt_w
        $error("CNT_W too narrow to hold DEPTH");
    end

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      track_pc_q, track_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];

    logic             has_credit;
    logic [SUM_W-1:0] in_use;
    logic             req_fire;
    logic             resp_take;
    logic             resp_keep;
    logic             pop;
    logic [31:0]      target_pc;
    logic             redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];
    assign target_pc           = {redirect_pc[31:2], 2'b00};

    // Credit: stored entries plus in-flight requests never exceed DEPTH
    always_comb begin
        in_use     = SUM_W'(count_q) + SUM_W'(outst_q);
        has_credit = (in_use < SUM_W'(DEPTH));
    end

    assign mem_req_valid = !reset && !redirect_valid && has_credit;
    assign mem_req_addr  = fetch_pc_q;

    assign dec_valid = !reset && (count_q != '0);
    assign dec_pc    = reset ? 32'h0 : pc_mem_q[rd_ptr_q];
    assign dec_inst  = reset ? 32'h0 : inst_mem_q[rd_ptr_q];
    assign occupancy = reset ? '0 : count_q;

    // Event decode and next-state
    always_comb begin
        req_fire  = mem_req_valid && mem_req_ready;
        resp_take = mem_resp_valid && (outst_q != '0);
        resp_keep = resp_take && (drop_q == '0) && !redirect_valid;
        pop       = dec_valid && dec_ready && !redirect_valid;

        fetch_pc_d = fetch_pc_q;
        track_pc_d = track_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        outst_d    = outst_q + CNT_W'(req_fire) - CNT_W'(resp_take);

        if (redirect_valid) begin
            // Everything still in flight belongs to the old path
            fetch_pc_d = target_pc;
            track_pc_d = target_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = outst_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_take && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (resp_keep) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                track_pc_d = track_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(resp_keep) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            track_pc_q <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            track_pc_q <= track_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Entry storage; written only for responses that survive the drop filter
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else if (resp_keep) begin
            pc_mem_q[wr_ptr_q]   <= track_pc_q;
            inst_mem_q[wr_ptr_q] <= mem_resp_data;
        end
    end

    resp_without_request_a : assert property (
        @(posedge clock) disable iff (reset) !(mem_resp_valid && (outst_q == '0))
    );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized scoreboard bench for fetch_prefetch_queue with an in-order imem model.
module tb_fetch_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CNT_W    = 3;
    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    logic             clock = 1'b0;
    logic             reset;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             mem_req_valid;
    logic [31:0]      mem_req_addr;
    logic             mem_req_ready;
    logic             mem_resp_valid;
    logic [31:0]      mem_resp_data;
    logic             dec_valid;
    logic [31:0]      dec_pc;
    logic [31:0]      dec_inst;
    logic             dec_ready;
    logic [CNT_W-1:0] occupancy;

    fetch_prefetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_ready(dec_ready),
        .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    req_t         pend[$];      // imem: accepted requests awaiting a response
    logic [31:0]  expq[$];      // PCs decode should still see, in order
    int unsigned  arr_cnt = 0;  // leading expq entries whose data has arrived
    int unsigned  stale_cnt = 0;// leading pend entries belonging to a flushed path
    logic [31:0]  model_pc = RESET_PC;
    int unsigned  last_due = 0;
    int unsigned  cyc = 0;
    int           checks = 0;
    int           failures = 0;
    int unsigned  delivered = 0;

    int unsigned  p_req = 100, p_dec = 100, p_redir = 0, lat_min = 0, lat_max = 0;
    bit           track_first = 0;
    int           first_acc = -1, first_dec = -1;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: inputs and outputs are stable at the falling edge
    always @(negedge clock) begin : mon
        req_t r;
        int unsigned occ;
        occ = arr_cnt;
        if (reset) begin
            chk("rst_dec_valid", 32'(dec_valid), 32'd0);
            chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
            chk("rst_occupancy", 32'(occupancy), 32'd0);
            chk("rst_dec_pc", dec_pc, 32'd0);
            chk("rst_dec_inst", dec_inst, 32'd0);
            pend.delete();
            expq.delete();
            arr_cnt   = 0;
            stale_cnt = 0;
            model_pc  = RESET_PC;
            last_due  = 0;
        end else begin
            chk("occupancy", 32'(occupancy), occ);
            chk("dec_valid", 32'(dec_valid), 32'(occ > 0));
            chk("req_valid", 32'(mem_req_valid),
                32'(!redirect_valid && (occ + pend.size() < DEPTH)));
            chk("req_addr", mem_req_addr, model_pc);
            if (occ > 0) begin
                chk("dec_pc", dec_pc, expq[0]);
                chk("dec_inst", dec_inst, inst_of(expq[0]));
            end
            if (track_first && dec_valid && first_dec < 0) first_dec = int'(cyc);
            if (redirect_valid) begin
                if (mem_resp_valid && pend.size() > 0) r = pend.pop_front();
                stale_cnt = pend.size();
                expq.delete();
                arr_cnt  = 0;
                model_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (occ > 0 && dec_ready) begin
                    void'(expq.pop_front());
                    arr_cnt--;
                    delivered++;
                end
                if (mem_resp_valid && pend.size() > 0) begin
                    r = pend.pop_front();
                    if (stale_cnt > 0) stale_cnt--;
                    else if (arr_cnt < expq.size()) arr_cnt++;
                end
                if (mem_req_valid && mem_req_ready) begin
                    r.addr = model_pc;
                    r.due  = cyc + 1 + lat_min + $urandom_range(lat_max - lat_min);
                    if (r.due < last_due) r.due = last_due;
                    last_due = r.due;
                    pend.push_back(r);
                    expq.push_back(model_pc);
                    if (track_first && first_acc < 0) first_acc = int'(cyc);
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    end

    // One clock of stimulus: imem answers its oldest due request, others randomized
    task automatic tick();
        @(posedge clock);
        #1;
        mem_resp_valid = (pend.size() > 0) && (pend[0].due <= cyc);
        mem_resp_data  = mem_resp_valid ? inst_of(pend[0].addr) : 32'hDEAD_BEEF;
        mem_req_ready  = ($urandom_range(99) < p_req);
        dec_ready      = ($urandom_range(99) < p_dec);
        redirect_valid = ($urandom_range(999) < p_redir);
        redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                  : $urandom;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        int unsigned d0;
        bit found;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0; dec_ready = 1'b0;
        repeat (3) tick();

        // Free run: 1-cycle imem, decode always ready
        p_req = 100; p_dec = 100; lat_min = 0; lat_max = 0; p_redir = 0;
        track_first = 1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        d0 = delivered;
        repeat (10) tick();
        chk("throughput", delivered - d0, 32'd10);
        chk("first_latency", 32'(first_dec - first_acc), 32'd2);
        track_first = 0;

        // Decode stall fills the queue and closes the credit window
        p_dec = 0;
        repeat (10) tick();
        @(negedge clock);
        chk("stall_occupancy", 32'(occupancy), 32'd4);
        chk("stall_req_valid", 32'(mem_req_valid), 32'd0);
        p_dec = 100;
        repeat (10) tick();

        // Redirect with slow imem so responses are still in flight
        lat_min = 3; lat_max = 3;
        repeat (8) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0100;
        tick();
        @(negedge clock);
        chk("redir_occupancy", 32'(occupancy), 32'd0);
        chk("redir_dec_valid", 32'(dec_valid), 32'd0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            @(negedge clock);
            if (dec_valid) begin
                found = 1;
                chk("redir_target_pc", dec_pc, 32'h0100_0100);
            end
        end
        if (!found) chk("redir_target_seen", 32'd0, 32'd1);

        // Redirect in the same cycle as a response and a pop
        lat_min = 0; lat_max = 2;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (mem_resp_valid && dec_valid) begin
                found = 1;
                redirect_valid = 1'b1; redirect_pc = 32'h0100_0206; dec_ready = 1'b1;
            end
        end
        chk("coincide_found", 32'(found), 32'd1);
        tick();
        @(negedge clock);
        chk("coincide_occupancy", 32'(occupancy), 32'd0);
        chk("coincide_req_addr", mem_req_addr, 32'h0100_0204);
        repeat (10) tick();

        // Request-ready toggling with 3-cycle responses
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 40; i++) begin
            tick();
            mem_req_ready = i[0];
        end

        // Random mix including redirects and address wrap
        p_req = 70; p_dec = 70; p_redir = 40; lat_min = 0; lat_max = 4;
        repeat (800) tick();

        // Reset while full
        p_req = 100; p_dec = 0; p_redir = 0; lat_min = 0; lat_max = 0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            @(negedge clock);
            if (occupancy == CNT_W'(DEPTH)) found = 1;
        end
        chk("full_before_reset", 32'(found), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_dec_valid", 32'(dec_valid), 32'd0);
        chk("post_reset_occupancy", 32'(occupancy), 32'd0);
        chk("post_reset_req_addr", mem_req_addr, RESET_PC);
        p_dec = 100;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
